// File: rtl/seq_multiplier_pkg.sv
// Shared state encoding and default operand width for the shift-add multiplier.
package seq_multiplier_pkg;

    localparam int MUL_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_dp.sv
// Shift-add datapath: one multiplier bit per step; result_o is the accumulator value after the current step.
// SEQ_MULTIPLIER_SIGNED_EN latches operand magnitudes plus a product sign and negates the result.
module seq_multiplier_dp
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     in_1_i,
    input  logic [WIDTH-1:0]     in_2_i,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    acc_next;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] op_a, op_b;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic sign_q, sign_d;

    // Magnitude of the most-negative value still fits as an unsigned WIDTH-bit number.
    assign op_a = in_1_i[WIDTH-1] ? -in_1_i : in_1_i;
    assign op_b = in_2_i[WIDTH-1] ? -in_2_i : in_2_i;
`else
    assign op_a = in_1_i;
    assign op_b = in_2_i;
`endif

    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        sign_d   = sign_q;
`endif
        if (load_i) begin
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            mplier_d = op_b;
            acc_d    = '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            sign_d   = in_1_i[WIDTH-1] ^ in_2_i[WIDTH-1];
`endif
        end else if (step_i) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            sign_q   <= sign_d;
`endif
        end
    end

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    assign result_o = sign_q ? -acc_next : acc_next;
`else
    assign result_o = acc_next;
`endif

endmodule

// File: rtl/seq_multiplier.sv
// Sequential multiplier: accept when idle, product valid exactly WIDTH cycles later, held until out_ready.
// Operands ignored outside IDLE; SEQ_MULTIPLIER_SIGNED_EN selects two's-complement operation in the datapath.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_1,
    input  logic [WIDTH-1:0]     in_2,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]   result;
    logic                 load, step;

    assign in_ready  = (state_q == ST_IDLE);
    assign load      = in_ready && in_valid;
    assign step      = (state_q == ST_BUSY);
    assign out       = out_q;
    assign out_valid = out_valid_q;

    seq_multiplier_dp #(
        .WIDTH    (WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .in_1_i   (in_1),
        .in_2_i   (in_2),
        .result_o (result)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Last iteration: capture the accumulator including this step's add.
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_DONE;
                    out_d       = result;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random bench for seq_multiplier at WIDTH 2, 8 and 16.
module tb_seq_multiplier;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ordy = 1'b0;

    logic [1:0]  a2 = '0, b2 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        iv2 = 1'b0, iv8 = 1'b0, iv16 = 1'b0;
    logic        irdy2, irdy8, irdy16;
    logic        ovld2, ovld8, ovld16;
    logic [3:0]  o2;
    logic [15:0] o8;
    logic [31:0] o16;

    int total = 0;
    int bad = 0;
    int sel = 0;
    logic [63:0] cur_out;
    logic        cur_ovld, cur_irdy;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_1(a2), .in_2(b2), .in_valid(iv2), .in_ready(irdy2),
        .out(o2), .out_valid(ovld2), .out_ready(ordy));
    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_1(a8), .in_2(b8), .in_valid(iv8), .in_ready(irdy8),
        .out(o8), .out_valid(ovld8), .out_ready(ordy));
    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_1(a16), .in_2(b16), .in_valid(iv16), .in_ready(irdy16),
        .out(o16), .out_valid(ovld16), .out_ready(ordy));

    always_comb begin
        cur_out  = '0;
        cur_ovld = 1'b0;
        cur_irdy = 1'b0;
        case (sel)
            0:       begin cur_out = {60'b0, o2};  cur_ovld = ovld2;  cur_irdy = irdy2;  end
            1:       begin cur_out = {48'b0, o8};  cur_ovld = ovld8;  cur_irdy = irdy8;  end
            default: begin cur_out = {32'b0, o16}; cur_ovld = ovld16; cur_irdy = irdy16; end
        endcase
    end

    function automatic int wof(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 8 : 16);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input int s, input logic v, input logic [31:0] a, input logic [31:0] b);
        case (s)
            0:       begin iv2 = v;  a2 = a[1:0];  b2 = b[1:0];  end
            1:       begin iv8 = v;  a8 = a[7:0];  b8 = b[7:0];  end
            default: begin iv16 = v; a16 = a[15:0]; b16 = b[15:0]; end
        endcase
    endtask

    // One full transaction; during a backpressure hold, new operands (na, nb) are offered.
    task automatic op(input int s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                      input int hold, input logic [31:0] na, input logic [31:0] nb, input string nm);
        int lat;
        sel = s;
        set_in(s, 1'b1, a, b);
        #0;
        chk({nm, " in_ready idle"}, {63'b0, cur_irdy}, 64'd1);
        @(posedge clk); #1;
        set_in(s, 1'b0, a, b);
        lat = 0;
        while (!cur_ovld && lat < 100) begin
            chk({nm, " in_ready busy"}, {63'b0, cur_irdy}, 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(wof(s)));
        chk({nm, " product"}, cur_out, exp);
        if (hold > 0) set_in(s, 1'b1, na, nb);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({nm, " hold valid"}, {63'b0, cur_ovld}, 64'd1);
            chk({nm, " hold out"}, cur_out, exp);
            chk({nm, " hold in_ready"}, {63'b0, cur_irdy}, 64'd0);
        end
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        chk({nm, " valid cleared"}, {63'b0, cur_ovld}, 64'd0);
        chk({nm, " in_ready after"}, {63'b0, cur_irdy}, 64'd1);
    endtask

    vec_t t2[5];
    vec_t t8[4];
    logic [63:0] q[$];

    initial begin
        int sent, got, cyc;
        logic acc;
        logic [63:0] expv;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
        t2[0] = '{32'd2, 32'd3, 64'h2};
        t2[1] = '{32'd1, 32'd2, 64'hE};
        t2[2] = '{32'd0, 32'd3, 64'h0};
        t2[3] = '{32'd3, 32'd3, 64'h1};
        t2[4] = '{32'd1, 32'd1, 64'h1};
        t8[0] = '{32'hFD, 32'h05, 64'hFFF1};
        t8[1] = '{32'h80, 32'h80, 64'h4000};
        t8[2] = '{32'h7F, 32'hFF, 64'hFF81};
        t8[3] = '{32'h00, 32'hF9, 64'h0};
`else
        t2[0] = '{32'd2, 32'd3, 64'd6};
        t2[1] = '{32'd1, 32'd2, 64'd2};
        t2[2] = '{32'd0, 32'd3, 64'd0};
        t2[3] = '{32'd3, 32'd3, 64'd9};
        t2[4] = '{32'd1, 32'd1, 64'd1};
        t8[0] = '{32'd255, 32'd255, 64'd65025};
        t8[1] = '{32'd0, 32'd200, 64'd0};
        t8[2] = '{32'd1, 32'd1, 64'd1};
        t8[3] = '{32'd15, 32'd17, 64'd255};
`endif

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            chk("reset out", cur_out, 64'd0);
            chk("reset out_valid", {63'b0, cur_ovld}, 64'd0);
            chk("reset in_ready", {63'b0, cur_irdy}, 64'd1);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) op(0, t2[i].a, t2[i].b, t2[i].p, 0, 0, 0, "w2");
        for (int i = 0; i < 4; i++) op(1, t8[i].a, t8[i].b, t8[i].p, 0, 0, 0, "w8");

        op(1, 32'd12, 32'd13, 64'd156, 5, 32'd7, 32'd7, "bp");
        op(1, 32'd7, 32'd7, 64'd49, 0, 0, 0, "bp next");

        // Abort in the 4th BUSY cycle of 100x100.
        sel = 1;
        set_in(1, 1'b1, 32'd100, 32'd100);
        @(posedge clk); #1;
        set_in(1, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort out", cur_out, 64'd0);
        chk("abort out_valid", {63'b0, cur_ovld}, 64'd0);
        chk("abort in_ready", {63'b0, cur_irdy}, 64'd1);
        op(1, 32'd3, 32'd4, 64'd12, 0, 0, 0, "post abort");

        sel = 2;
        sent = 0;
        got = 0;
        cyc = 0;
        set_in(2, 1'b1, $urandom, $urandom);
        while ((sent < 1000 || got < 1000) && cyc < 60000) begin
            @(negedge clk);
            acc = 1'b0;
            if (iv16 && irdy16) begin
`ifdef SEQ_MULTIPLIER_SIGNED_EN
                expv = {32'b0, 32'($signed(a16) * $signed(b16))};
`else
                expv = 64'(a16) * 64'(b16);
`endif
                q.push_back(expv);
                sent++;
                acc = 1'b1;
            end
            if (ovld16 && ordy) begin
                if (q.size() == 0) begin
                    chk("rand extra product", {32'b0, o16}, 64'hDEAD);
                end else begin
                    chk("rand product", {32'b0, o16}, q.pop_front());
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (sent < 1000) set_in(2, 1'b1, $urandom, $urandom);
                else iv16 = 1'b0;
            end
            ordy = 1'($urandom_range(0, 1));
        end
        ordy = 1'b0;
        chk("rand received", 64'(got), 64'd1000);
        chk("rand leftover", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
